// File: rtl/rou_buf_alloc_pkg.sv
// Shared types and helpers for the roubus buffer-pool allocator.
package rou_alloc_pkg;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned IDX_W = 6;

  typedef logic [NREQ-1:0]  req_vec_t;
  typedef logic [IDX_W-1:0] buf_idx_t;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rou_buf_alloc_if.sv
// Request/grant, release and status signals between the allocator and its clients.
interface rou_buf_alloc_if #(
  parameter int unsigned WBUFS = 6
);
  import rou_alloc_pkg::*;

  req_vec_t          req;
  req_vec_t          gnt;
  logic [WBUFS-1:0]  gnt_idx0;
  logic [WBUFS-1:0]  gnt_idx1;
  logic [WBUFS-1:0]  gnt_idx2;
  logic              free0_vld;
  logic              free1_vld;
  logic [WBUFS-1:0]  free0_idx;
  logic [WBUFS-1:0]  free1_idx;
  logic [WBUFS-1:0]  availables;
  logic              almost_empty;
  logic              err;

  modport master (
    output req, free0_vld, free1_vld, free0_idx, free1_idx,
    input  gnt, gnt_idx0, gnt_idx1, gnt_idx2, availables, almost_empty, err
  );

  modport slave (
    input  req, free0_vld, free1_vld, free0_idx, free1_idx,
    output gnt, gnt_idx0, gnt_idx1, gnt_idx2, availables, almost_empty, err
  );

endinterface

// File: rtl/rou_buf_alloc_free_pick.sv
// Finds the three lowest-numbered free buffers and how many (capped at 3) exist.
module rou_free_pick #(
  parameter int unsigned BUFS  = 8,
  parameter int unsigned WBUFS = 6
) (
  input  logic [BUFS-1:0]  occupied_i,
  output logic [WBUFS-1:0] f0_o,
  output logic [WBUFS-1:0] f1_o,
  output logic [WBUFS-1:0] f2_o,
  output logic             v0_o,
  output logic             v1_o,
  output logic             v2_o,
  output logic [1:0]       nfree_o
);

  logic [1:0] cnt;

  always_comb begin
    f0_o = '0;
    f1_o = '0;
    f2_o = '0;
    v0_o = 1'b0;
    v1_o = 1'b0;
    v2_o = 1'b0;
    cnt  = 2'd0;
    for (int unsigned i = 0; i < BUFS; i++) begin
      if (!occupied_i[i]) begin
        case (cnt)
          2'd0:    begin f0_o = WBUFS'(i); v0_o = 1'b1; end
          2'd1:    begin f1_o = WBUFS'(i); v1_o = 1'b1; end
          2'd2:    begin f2_o = WBUFS'(i); v2_o = 1'b1; end
          default: ;
        endcase
        if (cnt != 2'd3) cnt = cnt + 2'd1;
      end
    end
    nfree_o = cnt;
  end

endmodule

// File: rtl/rou_buf_alloc.sv
// Buffer-pool allocator: round-robin grants of lowest free indices, dual-port
// release with error tracking, registered free count and low-watermark flag.
module rou_buf_alloc
  import rou_alloc_pkg::*;
#(
  parameter int unsigned BUFS    = 8,
  parameter int unsigned WBUFS   = 6,
  parameter int unsigned LOWMARK = 2
) (
  input logic            clk,
  input logic            rst_n,
  rou_buf_alloc_if.slave bus
);

  logic [BUFS-1:0]  occ_q, occ_d, clr, alloc, oh0, oh1;
  logic [1:0]       rr_q, rr_d;
  req_vec_t         gnt_q, gnt_d, r_mask;
  logic [WBUFS-1:0] idx0_q, idx1_q, idx2_q, idx0_d, idx1_d, idx2_d;
  logic [WBUFS-1:0] avail_q, avail_d;
  logic             ae_q, ae_d, err_q, err_d;
  logic [WBUFS-1:0] f0, f1, f2, pick;
  logic             v0, v1, v2, hit0, hit1;
  logic [1:0]       nf, ng;
  logic [2:0]       p;

  rou_free_pick #(.BUFS(BUFS), .WBUFS(WBUFS)) u_pick (
    .occupied_i (occ_q),
    .f0_o       (f0),
    .f1_o       (f1),
    .f2_o       (f2),
    .v0_o       (v0),
    .v1_o       (v1),
    .v2_o       (v2),
    .nfree_o    (nf)
  );

  // Scan from rr; the n-th granted port in scan order takes the n-th free index.
  always_comb begin
    r_mask = bus.req & ~gnt_q;
    gnt_d  = '0;
    idx0_d = '0;
    idx1_d = '0;
    idx2_d = '0;
    rr_d   = rr_q;
    ng     = 2'd0;
    p      = 3'd0;
    pick   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      p = {1'b0, rr_q} + 3'(k);
      if (p >= 3'd3) p = p - 3'd3;
      if (r_mask[p[1:0]] && (ng < nf)) begin
        gnt_d[p[1:0]] = 1'b1;
        pick = (ng == 2'd0) ? f0 : (ng == 2'd1) ? f1 : f2;
        case (p[1:0])
          2'd0:    idx0_d = pick;
          2'd1:    idx1_d = pick;
          default: idx2_d = pick;
        endcase
        ng   = ng + 2'd1;
        rr_d = (p == 3'd2) ? 2'd0 : p[1:0] + 2'd1;
      end
    end
  end

  // Only occupied bits can be cleared, so dual or bogus frees never double-count.
  always_comb begin
    for (int unsigned i = 0; i < BUFS; i++) begin
      oh0[i]   = (bus.free0_idx == WBUFS'(i));
      oh1[i]   = (bus.free1_idx == WBUFS'(i));
      alloc[i] = ((ng > 2'd0) && v0 && (f0 == WBUFS'(i))) ||
                 ((ng > 2'd1) && v1 && (f1 == WBUFS'(i))) ||
                 ((ng > 2'd2) && v2 && (f2 == WBUFS'(i)));
    end
    hit0    = |(oh0 & occ_q);
    hit1    = |(oh1 & occ_q);
    clr     = ((bus.free0_vld ? oh0 : '0) | (bus.free1_vld ? oh1 : '0)) & occ_q;
    err_d   = err_q
            | (bus.free0_vld && !hit0)
            | (bus.free1_vld && !hit1)
            | (bus.free0_vld && bus.free1_vld && (bus.free0_idx == bus.free1_idx));
    occ_d   = (occ_q & ~clr) | alloc;
    avail_d = WBUFS'(BUFS) - WBUFS'(popcount(32'(occ_d)));
    ae_d    = (avail_d <= WBUFS'(LOWMARK));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= '0;
      rr_q    <= 2'd0;
      gnt_q   <= '0;
      idx0_q  <= '0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      avail_q <= WBUFS'(BUFS);
      ae_q    <= (BUFS <= LOWMARK);
      err_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      idx0_q  <= idx0_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      avail_q <= avail_d;
      ae_q    <= ae_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.gnt_idx0     = idx0_q;
  assign bus.gnt_idx1     = idx1_q;
  assign bus.gnt_idx2     = idx2_q;
  assign bus.availables   = avail_q;
  assign bus.almost_empty = ae_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_rou_buf_alloc.sv
// Directed-vector bench for rou_buf_alloc with hand-computed expectations.
module tb_rou_buf_alloc;
  import rou_alloc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  rou_buf_alloc_if #(.WBUFS(6)) bus ();

  rou_buf_alloc #(.BUFS(8), .WBUFS(6), .LOWMARK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_free(input logic v0, input buf_idx_t i0, input logic v1, input buf_idx_t i1);
    bus.free0_vld = v0;
    bus.free0_idx = i0;
    bus.free1_vld = v1;
    bus.free1_idx = i1;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;
    set_free(1'b0, 6'd0, 1'b0, 6'd0);
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_idx0", 32'(bus.gnt_idx0), 0);
    chk("rst_avail", 32'(bus.availables), 8);
    chk("rst_ae", 32'(bus.almost_empty), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst_n = 1'b1;

    // first allocation: three grants, indices 0,1,2
    bus.req = 3'b111;
    tick();
    chk("a1_gnt", 32'(bus.gnt), 7);
    chk("a1_idx0", 32'(bus.gnt_idx0), 0);
    chk("a1_idx1", 32'(bus.gnt_idx1), 1);
    chk("a1_idx2", 32'(bus.gnt_idx2), 2);
    chk("a1_avail", 32'(bus.availables), 5);
    bus.req = '0;
    tick();
    chk("a1_idle", 32'(bus.gnt), 0);

    bus.req = 3'b111;
    tick();
    chk("a2_gnt", 32'(bus.gnt), 7);
    chk("a2_idx0", 32'(bus.gnt_idx0), 3);
    chk("a2_idx2", 32'(bus.gnt_idx2), 5);
    chk("a2_avail", 32'(bus.availables), 2);
    chk("a2_ae", 32'(bus.almost_empty), 1);
    bus.req = '0;
    tick();
    bus.req = 3'b011;
    tick();
    chk("a3_gnt", 32'(bus.gnt), 3);
    chk("a3_idx0", 32'(bus.gnt_idx0), 6);
    chk("a3_idx1", 32'(bus.gnt_idx1), 7);
    chk("a3_avail", 32'(bus.availables), 0);
    bus.req = '0;
    set_free(1'b1, 6'd6, 1'b0, 6'd0);
    tick();
    chk("f6_avail", 32'(bus.availables), 1);
    set_free(1'b0, 6'd0, 1'b0, 6'd0);
    bus.req = 3'b100;
    tick();
    chk("p2_gnt", 32'(bus.gnt), 4);
    chk("p2_idx2", 32'(bus.gnt_idx2), 6);
    bus.req = '0;
    set_free(1'b1, 6'd6, 1'b0, 6'd0);
    tick();
    set_free(1'b0, 6'd0, 1'b0, 6'd0);

    // only idx 6 free, rr=0, all request
    bus.req = 3'b111;
    tick();
    chk("one_gnt", 32'(bus.gnt), 1);
    chk("one_idx0", 32'(bus.gnt_idx0), 6);
    chk("one_avail", 32'(bus.availables), 0);
    chk("one_ae", 32'(bus.almost_empty), 1);
    bus.req = '0;
    tick();

    // full pool, free idx 3: count rises next cycle, regrant one later to port 1
    bus.req = 3'b011;
    set_free(1'b1, 6'd3, 1'b0, 6'd0);
    tick();
    chk("fl_gnt_n1", 32'(bus.gnt), 0);
    chk("fl_avail_n1", 32'(bus.availables), 1);
    set_free(1'b0, 6'd0, 1'b0, 6'd0);
    tick();
    chk("fl_gnt_n2", 32'(bus.gnt), 2);
    chk("fl_idx1_n2", 32'(bus.gnt_idx1), 3);
    chk("fl_avail_n2", 32'(bus.availables), 0);
    bus.req = '0;
    tick();

    // bring rr back to 0 via a port-2 grant of idx 0
    bus.req = 3'b100;
    set_free(1'b1, 6'd0, 1'b0, 6'd0);
    tick();
    set_free(1'b0, 6'd0, 1'b0, 6'd0);
    tick();
    chk("rr0_gnt", 32'(bus.gnt), 4);
    chk("rr0_idx2", 32'(bus.gnt_idx2), 0);

    // four contention rounds, one freed buffer each
    bus.req = 3'b111;
    begin
      logic [5:0] fidx [4];
      logic [2:0] egnt [4];
      fidx = '{6'd1, 6'd2, 6'd4, 6'd5};
      egnt = '{3'b001, 3'b010, 3'b100, 3'b001};
      for (int r = 0; r < 4; r++) begin
        set_free(1'b1, fidx[r], 1'b0, 6'd0);
        tick();
        chk("rot_wait", 32'(bus.gnt), 0);
        set_free(1'b0, 6'd0, 1'b0, 6'd0);
        tick();
        chk("rot_gnt", 32'(bus.gnt), 32'(egnt[r]));
        case (r)
          0, 3:    chk("rot_idx", 32'(bus.gnt_idx0), 32'(fidx[r]));
          1:       chk("rot_idx", 32'(bus.gnt_idx1), 32'(fidx[r]));
          default: chk("rot_idx", 32'(bus.gnt_idx2), 32'(fidx[r]));
        endcase
      end
    end
    bus.req = '0;
    tick();

    // release errors
    set_free(1'b1, 6'd4, 1'b0, 6'd0);
    tick();
    chk("e_ok_avail", 32'(bus.availables), 1);
    chk("e_ok_err", 32'(bus.err), 0);
    tick();
    chk("e_unocc_err", 32'(bus.err), 1);
    chk("e_unocc_avail", 32'(bus.availables), 1);
    set_free(1'b1, 6'd9, 1'b0, 6'd0);
    tick();
    chk("e_range_avail", 32'(bus.availables), 1);
    set_free(1'b1, 6'd2, 1'b1, 6'd2);
    tick();
    chk("e_dual_avail", 32'(bus.availables), 2);
    chk("e_dual_ae", 32'(bus.almost_empty), 1);
    set_free(1'b0, 6'd0, 1'b0, 6'd0);
    tick();
    chk("e_sticky", 32'(bus.err), 1);

    // reset mid-operation with 5 buffers allocated and a pending request
    set_free(1'b1, 6'd0, 1'b0, 6'd0);
    tick();
    chk("pre_rst_avail", 32'(bus.availables), 3);
    set_free(1'b0, 6'd0, 1'b0, 6'd0);
    bus.req = 3'b111;
    rst_n   = 1'b0;
    tick();
    chk("mr_gnt", 32'(bus.gnt), 0);
    chk("mr_avail", 32'(bus.availables), 8);
    chk("mr_err", 32'(bus.err), 0);
    chk("mr_ae", 32'(bus.almost_empty), 0);
    rst_n = 1'b1;
    tick();
    chk("pr_gnt", 32'(bus.gnt), 7);
    chk("pr_idx1", 32'(bus.gnt_idx1), 1);
    chk("pr_avail", 32'(bus.availables), 5);
    bus.req = '0;

    // full release back to all-free
    set_free(1'b1, 6'd0, 1'b1, 6'd1);
    tick();
    chk("fr_avail1", 32'(bus.availables), 7);
    set_free(1'b1, 6'd2, 1'b0, 6'd0);
    tick();
    chk("fr_avail2", 32'(bus.availables), 8);
    chk("fr_err", 32'(bus.err), 0);
    set_free(1'b0, 6'd0, 1'b0, 6'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rou_buf_alloc.md
# rou_buf_alloc

Buffer-pool allocator for the roubus router. It owns the `occupied` vector of the shared packet-buffer pool and grants free buffer indices to three requesters per cycle, lowest free index first. Contention is resolved with round-robin priority. It accepts buffer releases on two ports and reports a registered count of free buffers plus a low-watermark flag to the ingress flow control.

## Interface
- `BUFS`, 8, number of buffers in the pool (1..32).
- `WBUFS`, 6, width of buffer indices and of the free count.
- `LOWMARK`, 2, `almost_empty` is asserted when free count <= `LOWMARK`.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req[2:0]` input 3: per-requester allocation request, level.
- `gnt[2:0]` output 3: per-requester grant, one-cycle pulse.
- `gnt_idx0`, `gnt_idx1`, `gnt_idx2` output WBUFS each: granted buffer index, valid while the matching `gnt` bit is 1.
- `free0_vld`, `free1_vld` input 1 each: release strobes.
- `free0_idx`, `free1_idx` input WBUFS each: index being released.
- `availables` output WBUFS: number of unoccupied buffers, registered.
- `almost_empty` output 1: registered, `availables <= LOWMARK`.
- `err` output 1: sticky protocol-error flag; cleared only by reset.

## Operation
- State registers:
  - `occupied[BUFS-1:0]`
  - round-robin pointer `rr` (0..2)
  - output registers
- Free-slot selection:
  - Each cycle, up to three lowest-numbered free indices f0 < f1 < f2 are found from registered `occupied`.
  - F = min(3, number of free buffers).
- Request masking: a requester whose `gnt` bit is 1 this cycle has its `req` ignored this cycle. It must still hold `req` (or re-assert it) to get another buffer.
- Arbitration:
  - Let R = masked requests.
  - If popcount(R) <= F, every requester in R is granted.
  - Otherwise, scan ports in order rr, rr+1, rr+2 (mod 3) and grant the first F requesters found.
- Index assignment: granted ports, taken in that same scan order, receive f0, f1, f2 respectively.
- Pointer update: `rr` moves to (last granted port + 1) mod 3 whenever at least one grant is issued; otherwise it is unchanged.
- Allocation effect: a granted index's `occupied` bit is set in the same edge that asserts `gnt`.
- Release:
  - A valid free clears `occupied[idx]` at the next edge.
  - A buffer released in cycle N is not visible to allocation until N+1.
- Release errors (`err` set):
  - A free with idx >= `BUFS`, or of a buffer not currently occupied: ignored.
  - Both free ports valid with the same idx: a single clear is performed.
- Counter: `availables` = `BUFS` − popcount(next `occupied`). Arithmetic is WBUFS wide; it never wraps, because the count is bounded by `BUFS`.
- No conflict exists between alloc and free in the same cycle. Allocation only selects free bits, and a legal free only touches occupied bits.

## Timing
- Reset values:
  - `occupied` = 0, `rr` = 0
  - `gnt` = 0, `gnt_idx*` = 0
  - `availables` = `BUFS`
  - `almost_empty` = (`BUFS` <= `LOWMARK`)
  - `err` = 0
- Allocation latency: `req` sampled at edge N, so `gnt` and `gnt_idx` are valid in cycle N+1, and `availables` reflects the allocation in N+1.
- Free latency: a free sampled at edge N clears the bit in N+1. `availables` rises in N+1, and the earliest regrant of that index is in cycle N+2.
- Empty pool (F = 0): no grants; `req` stays pending with no timeout; `rr` is held.
- Full release (all buffers freed): `availables` returns to `BUFS`.
- Reset mid-operation: all grants are dropped and the pool returns to all-free. Outstanding buffers are forgotten; requesters are reset together with this block.

## Structure
- Package `rou_alloc_pkg` holds:
  - `NREQ` = 3
  - the request/grant vector typedef
  - the index typedef sized by `WBUFS`
  - a `popcount` function
- Sub-module `rou_free_pick` (combinational) takes `occupied` and returns f0, f1, f2, their valid bits, and F.
- The top level holds the arbiter, the round-robin pointer, the `occupied` register, the free/error logic and the output registers.

## Test plan
- After reset, `req` = 3'b111 for 1 cycle -> next cycle `gnt` = 3'b111 with indices 0, 1, 2; `availables` = 5.
- All 8 buffers occupied except 6; `req` = 3'b111, `rr` = 0 -> only port 0 granted idx 6; `rr` = 1; `availables` = 0; `almost_empty` = 1.
- Pool full, hold `req` = 3'b011; free idx 3 at cycle N -> `availables` = 1 at N+1; grant of idx 3 at N+2 to the port at or after `rr`.
- Four rounds of full contention with one free buffer per round -> grants rotate across ports 0, 1, 2, 0.
- Free of an unoccupied idx 4, then free of idx 9 -> `occupied` unchanged and `err` = 1 persisting; dual free of idx 2 on both ports -> bit cleared once, `availables` +1, `err` = 1.
- Assert `rst_n` = 0 for one edge with 5 buffers allocated -> `availables` = 8, `gnt` = 0, `err` = 0 on the next cycle.
